// File: rtl/gbus_ahb_master_pkg.sv
// Shared AHB-Lite types and constants for the generic-bus to AHB master bridge.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_t;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_ERR2,
        ST_DONE
    } gam_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/gbus_ahb_master_if.sv
// Generic single-request bus between the access point and the AHB bridge.
interface generic_bus_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ren;
    logic        wen;
    logic        busy;
    logic [3:0]  byte_en;

    modport generic_bus (
        input  addr, wdata, ren, wen, byte_en,
        output rdata, busy
    );

    modport cpu (
        output addr, wdata, ren, wen, byte_en,
        input  rdata, busy
    );
endinterface

// File: rtl/gbus_ahb_master_byte_en_decode.sv
// Maps a generic-bus byte enable onto an AHB transfer size and low address bits.
module byte_en_decode
    import ahb_pkg::*;
(
    input  logic [3:0] byte_en_i,
    output hsize_t     hsize_o,
    output logic [1:0] offset_o,
    output logic       legal_o
);

    always_comb begin
        hsize_o  = HSIZE_WORD;
        offset_o = 2'b00;
        legal_o  = 1'b1;
        case (byte_en_i)
            4'b1111: begin hsize_o = HSIZE_WORD; offset_o = 2'b00; end
            4'b0011: begin hsize_o = HSIZE_HALF; offset_o = 2'b00; end
            4'b1100: begin hsize_o = HSIZE_HALF; offset_o = 2'b10; end
            4'b0001: begin hsize_o = HSIZE_BYTE; offset_o = 2'b00; end
            4'b0010: begin hsize_o = HSIZE_BYTE; offset_o = 2'b01; end
            4'b0100: begin hsize_o = HSIZE_BYTE; offset_o = 2'b10; end
            4'b1000: begin hsize_o = HSIZE_BYTE; offset_o = 2'b11; end
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/gbus_ahb_master.sv
// Turns single generic-bus requests into single NONSEQ AHB-Lite transfers,
// handling wait states and the two-cycle ERROR response.
//
// state | meaning
// IDLE  | waiting for ren/wen; latch request, decode byte_en
// ADDR  | address phase, NONSEQ held until HREADY
// DATA  | data phase, waiting for HREADY or first ERROR cycle
// ERR2  | second cycle of an ERROR response
// DONE  | busy low for one cycle, rdata/err valid
module gbus_ahb_master
    import ahb_pkg::*;
#(
    parameter logic [3:0]  HPROT_VAL  = 4'b0011,
    parameter int unsigned HMASTER_ID = 0
) (
    input  logic                    AFT_CLK,
    input  logic                    nRST,
    generic_bus_if.generic_bus      gbif,
    output logic                    err,
    output logic [31:0]             HADDR,
    output logic [1:0]              HTRANS,
    output logic                    HWRITE,
    output logic [2:0]              HSIZE,
    output logic [2:0]              HBURST,
    output logic [3:0]              HPROT,
    output logic [31:0]             HWDATA,
    input  logic [31:0]             HRDATA,
    input  logic                    HREADY,
    input  logic                    HRESP
);

    if (HMASTER_ID > 15) begin : g_bad_master_id
        $error("HMASTER_ID must fit in 4 bits");
    end

    gam_state_t  state_q;
    htrans_t     htrans_q;
    hsize_t      hsize_q;
    logic [31:0] haddr_q;
    logic        hwrite_q;
    logic [31:0] hwdata_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [7:0]  wait_cnt_q;
    logic        busy_d;

    hsize_t      dec_hsize;
    logic [1:0]  dec_offset;
    logic        dec_legal;

    byte_en_decode u_byte_en_decode (
        .byte_en_i (gbif.byte_en),
        .hsize_o   (dec_hsize),
        .offset_o  (dec_offset),
        .legal_o   (dec_legal)
    );

    always_ff @(posedge AFT_CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= ST_IDLE;
            htrans_q   <= HTRANS_IDLE;
            hsize_q    <= HSIZE_WORD;
            haddr_q    <= '0;
            hwrite_q   <= 1'b0;
            hwdata_q   <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    wait_cnt_q <= '0;
                    err_q      <= 1'b0;
                    if (gbif.ren || gbif.wen) begin
                        wdata_q <= gbif.wdata;
                        // Illegal enables complete without touching the bus.
                        if (dec_legal) begin
                            haddr_q  <= {gbif.addr[31:2], dec_offset};
                            hsize_q  <= dec_hsize;
                            hwrite_q <= gbif.wen;
                            htrans_q <= HTRANS_NONSEQ;
                            state_q  <= ST_ADDR;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_ADDR: begin
                    if (HREADY) begin
                        htrans_q <= HTRANS_IDLE;
                        if (hwrite_q) begin
                            hwdata_q <= wdata_q;
                        end
                        state_q <= ST_DATA;
                    end else begin
                        wait_cnt_q <= sat_inc8(wait_cnt_q);
                    end
                end
                ST_DATA: begin
                    if (HREADY) begin
                        if (HRESP) begin
                            err_q <= 1'b1;
                        end else if (!hwrite_q) begin
                            rdata_q <= HRDATA;
                        end
                        state_q <= ST_DONE;
                    end else begin
                        wait_cnt_q <= sat_inc8(wait_cnt_q);
                        if (HRESP) begin
                            state_q <= ST_ERR2;
                        end
                    end
                end
                ST_ERR2: begin
                    if (HREADY) begin
                        err_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    err_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // In IDLE busy follows the request so the requester sees it the same cycle.
    always_comb begin
        busy_d = 1'b0;
        case (state_q)
            ST_IDLE:                   busy_d = gbif.ren | gbif.wen;
            ST_ADDR, ST_DATA, ST_ERR2: busy_d = 1'b1;
            default:                   busy_d = 1'b0;
        endcase
    end

    assign gbif.busy  = busy_d;
    assign gbif.rdata = rdata_q;
    assign err        = err_q;
    assign HADDR      = haddr_q;
    assign HTRANS     = htrans_q;
    assign HWRITE     = hwrite_q;
    assign HSIZE      = hsize_q;
    assign HBURST     = HBURST_SINGLE;
    assign HPROT      = HPROT_VAL;
    assign HWDATA     = hwdata_q;

endmodule
